// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: fetch/load/store against block RAM and an I/O window
// Paced by a req/ready handshake with configurable wait states before each access.
module mem_access_unit #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    RAM_AW      = 10,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 16'hFF00,
   parameter int                    WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic                  mem_s,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [ADDR_WIDTH-1:0] addr_reg,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  instr_en,
   input  logic                  mem_reg_en,
   input  logic [9:0]            switches,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [9:0]            leds,
   output logic                  err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [ADDR_WIDTH-1:0] IO_LEDS = IO_BASE + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  we_q;
   logic                  instr_en_q;
   logic                  mem_reg_en_q;
   logic [9:0]            sw_meta;
   logic [9:0]            sw_sync;
   logic [DATA_WIDTH-1:0] ram [0:2**RAM_AW-1];

   logic ram_hit, is_sw, is_led, unmapped;

   // High address bits must be zero: no aliasing of the RAM above 2**RAM_AW.
   assign ram_hit  = (addr_q[ADDR_WIDTH-1:RAM_AW] == '0);
   assign is_sw    = (addr_q == IO_BASE);
   assign is_led   = (addr_q == IO_LEDS);
   assign unmapped = !(ram_hit || is_sw || is_led);

   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switches;
         sw_sync <= sw_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && state == S_ACCESS && we_q && ram_hit)
         ram[addr_q[RAM_AW-1:0]] <= wdata_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_data      <= '0;
         we_q         <= 1'b0;
         instr_en_q   <= 1'b0;
         mem_reg_en_q <= 1'b0;
         ready        <= 1'b0;
         err          <= 1'b0;
         instr        <= '0;
         mem_data     <= '0;
         leds         <= '0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0)
                  state <= S_ACCESS;
            end
            S_ACCESS: begin
               ready <= 1'b1;
               err   <= unmapped;
               state <= S_DONE;
               if (we_q && is_sw)
                  leds <= wdata_q[9:0];
               if (ram_hit)
                  rd_data <= ram[addr_q[RAM_AW-1:0]];
               else if (is_sw)
                  rd_data <= {{(DATA_WIDTH-10){1'b0}}, sw_sync};
               else if (is_led)
                  rd_data <= {{(DATA_WIDTH-10){1'b0}}, leds};
               else
                  rd_data <= '0;
            end
            S_DONE: begin
               if (!we_q && instr_en_q)
                  instr <= rd_data;
               if (!we_q && mem_reg_en_q)
                  mem_data <= rd_data;
            end
            default: ;
         endcase
         // DONE accepts a new request exactly like IDLE, giving back-to-back accesses.
         if (state == S_IDLE || state == S_DONE) begin
            if (req) begin
               addr_q       <= mem_s ? pc : addr_reg;
               we_q         <= we;
               wdata_q      <= wr_data;
               instr_en_q   <= instr_en;
               mem_reg_en_q <= mem_reg_en;
               cnt          <= CNT_INIT;
               state        <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end else begin
               state <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Random and directed accesses compared against an address-map model of RAM, LEDs and switches.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we, mem_s, instr_en, mem_reg_en;
   logic [15:0] pc, addr_reg, wr_data;
   logic [9:0]  switches;
   logic        ready, err;
   logic [15:0] instr, mem_data;
   logic [9:0]  leds;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] ram_m [int];
   logic [9:0]  leds_m;
   logic [15:0] instr_m, mem_m;

   localparam int LAT = 3;

   mem_access_unit dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .mem_s(mem_s),
      .pc(pc), .addr_reg(addr_reg), .wr_data(wr_data),
      .instr_en(instr_en), .mem_reg_en(mem_reg_en), .switches(switches),
      .ready(ready), .instr(instr), .mem_data(mem_data), .leds(leds), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic model_unmapped(input logic [15:0] a);
      return !(a < 16'd1024 || a == 16'hFF00 || a == 16'hFF01);
   endfunction

   task automatic model_apply(input logic w, input logic [15:0] a, input logic [15:0] d,
                              input logic ie, input logic me);
      logic [15:0] v;
      if (w) begin
         if (a < 16'd1024) ram_m[int'(a)] = d;
         else if (a == 16'hFF00) leds_m = d[9:0];
      end else begin
         if (a < 16'd1024) v = ram_m[int'(a)];
         else if (a == 16'hFF00) v = {6'b0, switches};
         else if (a == 16'hFF01) v = {6'b0, leds_m};
         else v = 16'h0000;
         if (ie) instr_m = v;
         if (me) mem_m = v;
      end
   endtask

   // Starts and ends at a negedge; returns ready latency in cycles after the capture edge.
   task automatic do_access(input logic w, input logic ms, input logic [15:0] a, input logic [15:0] d,
                            input logic ie, input logic me, output int lat, output logic e_seen);
      we = w; mem_s = ms; wr_data = d; instr_en = ie; mem_reg_en = me;
      if (ms) begin pc = a; addr_reg = 16'($urandom); end
      else begin addr_reg = a; pc = 16'($urandom); end
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      pc = 16'($urandom); addr_reg = 16'($urandom); wr_data = 16'($urandom);
      we = 1'($urandom); instr_en = 1'($urandom); mem_reg_en = 1'($urandom);
      lat = -1;
      e_seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (ready) begin
            lat = k;
            e_seen = err;
            break;
         end
         @(negedge clk);
      end
      model_apply(w, a, d, ie, me);
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0; req = 1'b1; we = 1'b0; mem_s = 1'b1; pc = 16'h0005;
      repeat (3) @(negedge clk);
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
      n_checks++; if (leds !== 10'h000) begin n_fail++; $display("FAIL reset_leds: got %h expected 000", leds); end
      n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
      n_checks++; if (mem_data !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_data: got %h expected 0000", mem_data); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      req = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ready: cycle %0d got %b expected 0", k, ready); end
      end
   endtask

   task automatic test_fetch;
      int lat; logic e;
      do_access(1'b1, 1'b0, 16'd5, 16'h1234, 1'b0, 1'b0, lat, e);
      do_access(1'b0, 1'b1, 16'd5, 16'h0000, 1'b1, 1'b0, lat, e);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL fetch_latency: got %0d expected %0d", lat, LAT); end
      n_checks++; if (instr !== 16'h1234) begin n_fail++; $display("FAIL fetch_instr: got %h expected 1234", instr); end
      n_checks++; if (mem_data !== mem_m) begin n_fail++; $display("FAIL fetch_mem_data: got %h expected %h", mem_data, mem_m); end
   endtask

   task automatic test_store_load;
      int lat; logic e;
      do_access(1'b1, 1'b0, 16'd7, 16'hBEEF, 1'b1, 1'b1, lat, e);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL store_latency: got %0d expected %0d", lat, LAT); end
      n_checks++; if (instr !== instr_m || mem_data !== mem_m) begin n_fail++;
         $display("FAIL store_no_latch: got %h/%h expected %h/%h", instr, mem_data, instr_m, mem_m); end
      do_access(1'b0, 1'b0, 16'd7, 16'h0000, 1'b0, 1'b1, lat, e);
      n_checks++; if (mem_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_mem_data: got %h expected beef", mem_data); end
   endtask

   task automatic test_io;
      int lat; logic e;
      do_access(1'b1, 1'b0, 16'hFF00, 16'h02A5, 1'b0, 1'b0, lat, e);
      n_checks++; if (leds !== 10'h2A5) begin n_fail++; $display("FAIL io_leds: got %h expected 2a5", leds); end
      switches = 10'h155;
      repeat (2) @(negedge clk);
      do_access(1'b0, 1'b0, 16'hFF00, 16'h0000, 1'b0, 1'b1, lat, e);
      n_checks++; if (mem_data !== 16'h0155) begin n_fail++; $display("FAIL io_switches: got %h expected 0155", mem_data); end
      do_access(1'b1, 1'b0, 16'hFF01, 16'h0033, 1'b0, 1'b0, lat, e);
      n_checks++; if (leds !== 10'h2A5 || e !== 1'b0) begin n_fail++; $display("FAIL io_led_rd_write: leds %h err %b expected 2a5 0", leds, e); end
      do_access(1'b0, 1'b1, 16'hFF01, 16'h0000, 1'b1, 1'b1, lat, e);
      n_checks++; if (instr !== 16'h02A5 || mem_data !== 16'h02A5) begin n_fail++;
         $display("FAIL io_led_readback: got %h/%h expected 02a5/02a5", instr, mem_data); end
   endtask

   task automatic test_unmapped;
      int lat; logic e;
      do_access(1'b1, 1'b0, 16'd0, 16'h5A5A, 1'b0, 1'b0, lat, e);
      do_access(1'b0, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, lat, e);
      n_checks++; if (lat !== LAT || e !== 1'b1) begin n_fail++; $display("FAIL unmapped_read: lat %0d err %b expected %0d 1", lat, e, LAT); end
      n_checks++; if (mem_data !== 16'h0000) begin n_fail++; $display("FAIL unmapped_mem_data: got %h expected 0000", mem_data); end
      do_access(1'b1, 1'b0, 16'h8000, 16'hFFFF, 1'b0, 1'b0, lat, e);
      n_checks++; if (e !== 1'b1 || leds !== leds_m) begin n_fail++; $display("FAIL unmapped_write: err %b leds %h expected 1 %h", e, leds, leds_m); end
      do_access(1'b1, 1'b0, 16'h0400, 16'hFFFF, 1'b0, 1'b0, lat, e);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped_0400: err %b expected 1", e); end
      do_access(1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, lat, e);
      n_checks++; if (mem_data !== 16'h5A5A || e !== 1'b0) begin n_fail++;
         $display("FAIL unmapped_ram_intact: got %h err %b expected 5a5a 0", mem_data, e); end
      do_access(1'b1, 1'b0, 16'h03FF, 16'h3FF3, 1'b0, 1'b0, lat, e);
      do_access(1'b0, 1'b1, 16'h03FF, 16'h0000, 1'b1, 1'b0, lat, e);
      n_checks++; if (instr !== 16'h3FF3 || e !== 1'b0) begin n_fail++; $display("FAIL ram_top_word: got %h err %b expected 3ff3 0", instr, e); end
   endtask

   task automatic test_random;
      int lat; logic e; logic [15:0] a; logic w; int kind;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 5) a = (kind <= 2) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(1020, 1023));
         else if (kind == 6) a = 16'hFF00;
         else if (kind == 7) a = 16'hFF01;
         else if (kind == 8) a = 16'($urandom_range(16'h0400, 16'hFEFF));
         else a = 16'($urandom_range(16'hFF02, 16'hFFFF));
         w = 1'($urandom);
         if (a < 16'd1024 && !ram_m.exists(int'(a))) w = 1'b1;
         switches = 10'($urandom);
         do_access(w, 1'($urandom), a, 16'($urandom), 1'($urandom), 1'($urandom), lat, e);
         n_checks++; if (lat !== LAT || e !== model_unmapped(a)) begin n_fail++;
            $display("FAIL rand_handshake: i %0d addr %h lat %0d err %b expected %0d %b", i, a, lat, e, LAT, model_unmapped(a)); end
         n_checks++; if (instr !== instr_m || mem_data !== mem_m || leds !== leds_m) begin n_fail++;
            $display("FAIL rand_regs: i %0d addr %h w %b got %h/%h/%h expected %h/%h/%h", i, a, w,
                     instr, mem_data, leds, instr_m, mem_m, leds_m); end
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic e; int k; int pend; int c [3];
      do_access(1'b1, 1'b0, 16'd0, 16'hA0A0, 1'b0, 1'b0, lat, e);
      do_access(1'b1, 1'b0, 16'd1, 16'hB1B1, 1'b0, 1'b0, lat, e);
      do_access(1'b1, 1'b0, 16'd2, 16'hC2C2, 1'b0, 1'b0, lat, e);
      c[0] = -100; c[1] = -100; c[2] = -100;
      k = 0; pend = -1;
      we = 1'b0; mem_s = 1'b1; instr_en = 1'b1; mem_reg_en = 1'b0; pc = 16'd0; req = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         if (pend >= 0) begin
            n_checks++; if (instr !== instr_m) begin n_fail++; $display("FAIL b2b_instr: fetch %0d got %h expected %h", pend, instr, instr_m); end
            pend = -1;
            if (k == 3) break;
         end
         if (ready) begin
            model_apply(1'b0, 16'(k), 16'h0000, 1'b1, 1'b0);
            c[k] = cyc; pend = k; k++;
            pc = 16'(k);
            if (k == 3) req = 1'b0;
         end
      end
      req = 1'b0;
      n_checks++; if (k !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d ready pulses expected 3", k); end
      n_checks++; if (c[0] !== LAT || c[1] - c[0] !== LAT || c[2] - c[1] !== LAT) begin n_fail++;
         $display("FAIL b2b_spacing: pulses at %0d %0d %0d expected %0d %0d %0d", c[0], c[1], c[2], LAT, 2*LAT, 3*LAT); end
      @(negedge clk);
   endtask

   task automatic test_reset_in_wait;
      int lat; logic e;
      do_access(1'b1, 1'b0, 16'd9, 16'h1111, 1'b0, 1'b0, lat, e);
      we = 1'b1; mem_s = 1'b0; addr_reg = 16'd9; wr_data = 16'h2222; req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      leds_m = '0; instr_m = '0; mem_m = '0;
      n_checks++; if (leds !== 10'h000 || mem_data !== 16'h0000) begin n_fail++;
         $display("FAIL wait_reset_regs: leds %h mem_data %h expected 000 0000", leds, mem_data); end
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL wait_reset_ready: cycle %0d got %b expected 0", k, ready); end
         @(negedge clk);
      end
      do_access(1'b0, 1'b0, 16'd9, 16'h0000, 1'b0, 1'b1, lat, e);
      n_checks++; if (mem_data !== 16'h1111) begin n_fail++; $display("FAIL wait_reset_ram: got %h expected 1111", mem_data); end
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; we = 1'b0; mem_s = 1'b0; pc = '0; addr_reg = '0;
      wr_data = '0; instr_en = 1'b0; mem_reg_en = 1'b0; switches = '0;
      leds_m = '0; instr_m = '0; mem_m = '0;
      @(negedge clk);
      test_reset;
      test_fetch;
      test_store_load;
      test_io;
      test_unmapped;
      test_random;
      test_back_to_back;
      test_reset_in_wait;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
